// File: rtl/ps2_command_tx.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module      : ps2_command_tx
//  Description : Host-to-device PS/2 command transmitter. Performs the host
//                request-to-send handshake on the shared open-drain
//                PS2_CLK/PS2_DAT pins, shifts one command byte out on
//                device-generated clock edges, checks the device acknowledge
//                and reports completion or error.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_command_tx #(
  parameter int CLK_HOLD_CYCLES   = 6000,
  parameter int DATA_SETUP_CYCLES = 50,
  parameter int START_TIMEOUT     = 750000,
  parameter int BIT_TIMEOUT       = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_send,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       cmd_busy,
  output logic       cmd_sent,
  output logic       cmd_error
);

  // One counter serves the inhibit/setup delays and the edge watchdog, so it
  // is sized for the largest of the four limits.
  localparam int c_max_a   = (CLK_HOLD_CYCLES > DATA_SETUP_CYCLES) ? CLK_HOLD_CYCLES : DATA_SETUP_CYCLES;
  localparam int c_max_b   = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
  localparam int c_cnt_max = (c_max_a > c_max_b) ? c_max_a : c_max_b;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(CLK_HOLD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_setup_last = c_cnt_w'(DATA_SETUP_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_start_last = c_cnt_w'(START_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_bit_last   = c_cnt_w'(BIT_TIMEOUT - 1);
  localparam logic [3:0]         c_last_bit   = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQUEST   = 3'd2,
    S_SHIFT     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t               r_state, w_state_next;
  logic [c_cnt_w-1:0]   r_count, w_count_next;
  logic [9:0]           r_shift, w_shift_next;   // {stop, parity, d7..d0}
  logic [3:0]           r_bit_idx, w_bit_idx_next;
  logic                 r_dat_bit, w_dat_bit_next; // level currently presented
  logic                 r_first, w_first_next;     // no device edge seen yet
  logic                 r_sent, w_sent_next;
  logic                 r_error, w_error_next;

  logic                 r_clk_meta, r_clk_sync, r_clk_prev;
  logic                 r_dat_meta, r_dat_sync;
  logic                 w_fall;
  logic [c_cnt_w-1:0]   w_limit;
  logic                 w_clk_low, w_dat_low;

  // Two-flop synchronisers on the shared pins; idle lines read high
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= PS2_CLK;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= PS2_DAT;
      r_dat_sync <= r_dat_meta;
    end
  end

  assign w_fall  = r_clk_prev & ~r_clk_sync;
  assign w_limit = r_first ? c_start_last : c_bit_last;

  // State and datapath registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_dat_bit <= 1'b1;
      r_first   <= 1'b0;
      r_sent    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_count   <= w_count_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_dat_bit <= w_dat_bit_next;
      r_first   <= w_first_next;
      r_sent    <= w_sent_next;
      r_error   <= w_error_next;
    end
  end

  // Next-state logic: handshake sequencing, bit shifting and watchdog
  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count + 1'b1;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_dat_bit_next = r_dat_bit;
    w_first_next   = r_first;
    w_sent_next    = 1'b0;
    w_error_next   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_count_next = '0;
        // A strobe coinciding with a completion pulse is not a new request
        if (cmd_send && !r_sent && !r_error) begin
          w_shift_next = {1'b1, ~^cmd_data, cmd_data};
          w_state_next = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (r_count == c_hold_last) begin
          w_count_next = '0;
          w_state_next = S_REQUEST;
        end
      end

      S_REQUEST: begin
        if (r_count == c_setup_last) begin
          w_count_next   = '0;
          w_bit_idx_next = '0;
          w_dat_bit_next = 1'b0;   // start bit stays on the line until edge 1
          w_first_next   = 1'b1;
          w_state_next   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (w_fall) begin
          w_count_next   = '0;
          w_first_next   = 1'b0;
          w_dat_bit_next = r_shift[r_bit_idx];
          if (r_bit_idx == c_last_bit) begin
            w_state_next = S_ACK;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end else if (r_count == w_limit) begin
          w_error_next = 1'b1;
          w_state_next = S_IDLE;
        end
      end

      S_ACK: begin
        if (w_fall) begin
          w_count_next = '0;
          if (!r_dat_sync) begin
            w_state_next = S_WAIT_IDLE;
          end else begin
            w_error_next = 1'b1;
            w_state_next = S_IDLE;
          end
        end else if (r_count == w_limit) begin
          w_error_next = 1'b1;
          w_state_next = S_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        if (r_clk_sync && r_dat_sync) begin
          w_sent_next  = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_fall) begin
          w_count_next = '0;
        end else if (r_count == w_limit) begin
          w_error_next = 1'b1;
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Pin drive derives from the state register so an asynchronous reset
  // releases both lines immediately.
  assign w_clk_low = (r_state == S_INHIBIT) || (r_state == S_REQUEST);
  assign w_dat_low = (r_state == S_REQUEST) || ((r_state == S_SHIFT) && !r_dat_bit);

  assign PS2_CLK   = w_clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT   = w_dat_low ? 1'b0 : 1'bz;

  assign cmd_busy  = (r_state != S_IDLE);
  assign cmd_sent  = r_sent;
  assign cmd_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_command_tx.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module      : tb_ps2_command_tx
//  Description : Self-checking bench for ps2_command_tx with a behavioural
//                PS/2 device model driving the open-drain bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_command_tx;

  localparam int HOLD     = 6000;
  localparam int SETUP    = 50;
  localparam int START_TO = 1500;
  localparam int BIT_TO   = 400;
  localparam int HALF     = 20;   // device clock half period in system cycles

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] cmd_data;
  logic       cmd_send;
  wire        ps2_clk;
  wire        ps2_dat;
  logic       cmd_busy;
  logic       cmd_sent;
  logic       cmd_error;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  ps2_command_tx #(
    .CLK_HOLD_CYCLES  (HOLD),
    .DATA_SETUP_CYCLES(SETUP),
    .START_TIMEOUT    (START_TO),
    .BIT_TIMEOUT      (BIT_TO)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .cmd_data (cmd_data),
    .cmd_send (cmd_send),
    .PS2_CLK  (ps2_clk),
    .PS2_DAT  (ps2_dat),
    .cmd_busy (cmd_busy),
    .cmd_sent (cmd_sent),
    .cmd_error(cmd_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  // Pulse monitor: running totals plus sticky protocol violations
  int   sent_cnt = 0;
  int   err_cnt  = 0;
  logic both_bad = 1'b0;
  logic busy_bad = 1'b0;
  always @(negedge CLOCK_50) begin
    if (cmd_sent) sent_cnt <= sent_cnt + 1;
    if (cmd_error) err_cnt <= err_cnt + 1;
    if (cmd_sent && cmd_error) both_bad <= 1'b1;
    if ((cmd_sent || cmd_error) && cmd_busy) busy_bad <= 1'b1;
  end

  typedef struct {
    logic [7:0]  cmd;
    logic        ack;
    logic [10:0] frame;   // {stop, parity, d7..d0, start}
    int          lat;     // cycles from 11th falling edge to the result pulse
    logic        sent;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_data = b;
    cmd_send = 1'b1;
    tick(1);
    cmd_send = 1'b0;
    check("busy_on_accept", int'(cmd_busy), 1);
    check("clk_inhibit_start", int'(ps2_clk), 0);
  endtask

  // Returns at the first cycle with PS2_CLK released
  task automatic measure_request(output int hold_n, output int setup_n);
    hold_n = 0;
    while (ps2_dat && hold_n < HOLD + 100) begin
      tick(1);
      hold_n++;
    end
    setup_n = 0;
    while (!ps2_clk && setup_n < SETUP + 100) begin
      tick(1);
      setup_n++;
    end
  endtask

  // Device clocks n_edges falling edges and samples DAT late in each low phase
  task automatic device_frame(input int n_edges, output logic [10:0] bits);
    bits = '0;
    tick(30);
    bits[0] = ps2_dat;
    for (int i = 1; i <= n_edges; i++) begin
      dev_clk_low = 1'b1;
      tick(HALF);
      bits[i] = ps2_dat;
      dev_clk_low = 1'b0;
      tick(HALF);
    end
  endtask

  // 11th edge with optional acknowledge; lat counts cycles to either pulse
  task automatic ack_edge(input logic ack, output int lat);
    dev_dat_low = ack;
    tick(5);
    dev_clk_low = 1'b1;
    lat = 0;
    while (!cmd_error && !cmd_sent && lat < 200) begin
      tick(1);
      lat++;
      if (lat == HALF) dev_clk_low = 1'b0;
      if (lat == HALF + 5) dev_dat_low = 1'b0;
    end
  endtask

  task automatic run_full(input logic [7:0] cmd, input logic ack,
                          input logic [10:0] exp_frame, input int exp_lat,
                          input logic exp_sent, input logic inject);
    int          s0, e0, h, s, lat;
    logic [10:0] bits;
    s0 = sent_cnt;
    e0 = err_cnt;
    send_cmd(cmd);
    measure_request(h, s);
    check("inhibit_cycles", h, HOLD);
    check("setup_cycles", s, SETUP);
    if (inject) begin
      cmd_data = ~cmd;
      cmd_send = 1'b1;
      tick(1);
      cmd_send = 1'b0;
      cmd_data = 8'h00;
    end
    device_frame(10, bits);
    check("frame_bits", int'(bits), int'(exp_frame));
    ack_edge(ack, lat);
    check("result_latency", lat, exp_lat);
    // A request in the pulse cycle must be dropped
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    cmd_data = 8'hAA;
    cmd_send = 1'b1;
    tick(1);
    cmd_send = 1'b0;
    check("send_at_pulse_ignored", int'(cmd_busy), 0);
    tick(3);
    check("clk_idle_after", int'(ps2_clk), 1);
    check("sent_pulses", sent_cnt - s0, int'(exp_sent));
    check("error_pulses", err_cnt - e0, int'(!exp_sent));
  endtask

  initial begin
    #1_900_000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          s0, e0, h, s, n;
    logic [10:0] bits;

    // Hand-computed frames {stop, odd parity, data, start}
    vecs[0] = '{cmd: 8'hED, ack: 1'b1, frame: 11'h7DA, lat: 28, sent: 1'b1};
    vecs[1] = '{cmd: 8'hF4, ack: 1'b1, frame: 11'h5E8, lat: 28, sent: 1'b1};
    vecs[2] = '{cmd: 8'h00, ack: 1'b1, frame: 11'h600, lat: 28, sent: 1'b1};
    vecs[3] = '{cmd: 8'h55, ack: 1'b0, frame: 11'h6AA, lat: 3,  sent: 1'b0};

    reset    = 1'b1;
    cmd_send = 1'b0;
    cmd_data = 8'h00;
    tick(3);
    check("reset_busy", int'(cmd_busy), 0);
    check("reset_sent", int'(cmd_sent), 0);
    check("reset_error", int'(cmd_error), 0);
    check("reset_clk_z", int'(ps2_clk), 1);
    check("reset_dat_z", int'(ps2_dat), 1);
    reset = 1'b0;
    tick(3);

    for (int i = 0; i < 4; i++) begin
      run_full(vecs[i].cmd, vecs[i].ack, vecs[i].frame, vecs[i].lat, vecs[i].sent, 1'b0);
    end

    // Request while busy is ignored; frame still carries 0xFF
    run_full(8'hFF, 1'b1, 11'h7FE, 28, 1'b1, 1'b1);

    // Device never clocks after release
    s0 = sent_cnt;
    e0 = err_cnt;
    send_cmd(8'hED);
    measure_request(h, s);
    n = 0;
    while (!cmd_error && n < START_TO + 50) begin
      tick(1);
      n++;
    end
    check("start_timeout_cycles", n, START_TO);
    check("timeout_clk_z", int'(ps2_clk), 1);
    check("timeout_dat_z", int'(ps2_dat), 1);
    check("timeout_busy", int'(cmd_busy), 0);
    tick(2);
    check("timeout_sent_pulses", sent_cnt - s0, 0);
    check("timeout_error_pulses", err_cnt - e0, 1);

    // Device stalls after the 4th edge; 2 sync stages + 1 register from the edge
    s0 = sent_cnt;
    e0 = err_cnt;
    send_cmd(8'h12);
    measure_request(h, s);
    device_frame(4, bits);
    check("stall_bits", int'(bits[4:0]), 5'b00100);
    n = 0;
    while (!cmd_error && n < BIT_TO + 50) begin
      tick(1);
      n++;
    end
    check("bit_timeout_cycles", n, BIT_TO + 3 - 2 * HALF);
    tick(2);
    check("stall_sent_pulses", sent_cnt - s0, 0);
    check("stall_error_pulses", err_cnt - e0, 1);
    run_full(8'hF4, 1'b1, 11'h5E8, 28, 1'b1, 1'b0);

    // Reset during the 6th data bit (d5 of 0x00 is driven low)
    s0 = sent_cnt;
    e0 = err_cnt;
    send_cmd(8'h00);
    measure_request(h, s);
    device_frame(6, bits);
    check("dat_driven_before_reset", int'(ps2_dat), 0);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_clk_z", int'(ps2_clk), 1);
    check("async_reset_dat_z", int'(ps2_dat), 1);
    check("async_reset_busy", int'(cmd_busy), 0);
    tick(3);
    reset = 1'b0;
    tick(5);
    check("reset_sent_pulses", sent_cnt - s0, 0);
    check("reset_error_pulses", err_cnt - e0, 0);

    check("pulses_exclusive", int'(both_bad), 0);
    check("busy_falls_with_pulse", int'(busy_bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_command_tx.md
Name: ps2_command_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xF4 (enable), from the FPGA to the keyboard. It sits beside the PS/2 receive path and shares the same open-drain PS2_CLK/PS2_DAT pins. It runs the full host request-to-send sequence, shifts out the frame on device-generated clock edges, checks the device acknowledge, and reports done or error.

Parameters:
CLK_HOLD_CYCLES, 6000, CLOCK_50 cycles that PS2_CLK is held low to inhibit the device (120 us at 50 MHz).
DATA_SETUP_CYCLES, 50, cycles PS2_DAT is held low before PS2_CLK is released.
START_TIMEOUT, 750000, maximum cycles from clock release to the first device falling edge (15 ms).
BIT_TIMEOUT, 100000, maximum cycles between consecutive device falling edges (2 ms).

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset
cmd_data  input  8  command byte; captured when a request is accepted
cmd_send  input  1  one-cycle request strobe
PS2_CLK  inout  1  open-drain; driven 0 or Z only
PS2_DAT  inout  1  open-drain; driven 0 or Z only
cmd_busy  output  1  high from the accept cycle until completion or error
cmd_sent  output  1  one-cycle pulse when the device acknowledge is received
cmd_error  output  1  one-cycle pulse on timeout or missing acknowledge

Behaviour:
- Reset and interface:
  - One clock. Reset is asynchronous and active-high: CLOCK_50 and reset.
  - In reset: PS2_CLK=Z, PS2_DAT=Z, cmd_busy=0, cmd_sent=0, cmd_error=0, FSM in IDLE, all counters 0.
- Input sampling: PS2_CLK and PS2_DAT each pass through a 2-FF synchroniser. A falling edge is declared when the synchronised clock was 1 on the previous cycle and is 0 now.
- Frame format: {stop=1, parity, d7..d0, start=0}, sent LSB first. Parity is odd: parity = ~^cmd_data.
- FSM:
  - IDLE: cmd_send=1 latches cmd_data into the shift register, sets cmd_busy=1 on the next cycle, and goes to INHIBIT.
  - INHIBIT: drive PS2_CLK low for CLK_HOLD_CYCLES, then go to REQUEST.
  - REQUEST: keep PS2_CLK low and drive PS2_DAT low (start bit) for DATA_SETUP_CYCLES. Then release PS2_CLK (Z) and go to SHIFT with bit index 0.
  - SHIFT: on each device falling edge, present the next bit: d0..d7, then parity, then stop. A bit value of 0 drives PS2_DAT low; a value of 1 releases it (Z). After the stop bit has been presented (10th falling edge), go to ACK with PS2_DAT released.
  - ACK: on the next falling edge (11th), sample PS2_DAT. A value of 0 goes to WAIT_IDLE. A value of 1 pulses cmd_error and goes to IDLE.
  - WAIT_IDLE: wait until both synchronised lines read 1, then pulse cmd_sent, clear cmd_busy, and go to IDLE.
- Timeouts:
  - A watchdog counter resets on every falling edge.
  - The first edge after clock release must arrive within START_TIMEOUT.
  - Each later edge must arrive within BIT_TIMEOUT. WAIT_IDLE also uses BIT_TIMEOUT.
  - On expiry: release both lines the same cycle, pulse cmd_error, clear cmd_busy, go to IDLE.
- Pulse exclusivity: cmd_sent and cmd_error are never both high in the same cycle. cmd_busy falls in the same cycle as either pulse.
- cmd_send while cmd_busy=1 is ignored. No queueing, and the shift register is unchanged.
- cmd_send in the same cycle as a completion pulse is ignored; a new request is accepted only from IDLE.
- Reset asserted mid-frame: both lines are released immediately (asynchronously), with no pulse.
- The receive path sees host-driven levels. The integrator must gate received_data_en with cmd_busy.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and acking → PS2_CLK low for 6000 cycles; DAT bits observed on successive falling edges = 0,1,0,1,1,0,1,1,1 (data LSB first, then parity=1), stop=1; cmd_sent pulses once, cmd_busy low afterwards.
- Send 0xF4 → data bits 0,0,1,0,1,1,1,1, parity=0, stop=1; cmd_sent pulses once.
- Device never clocks after release → cmd_error pulses exactly START_TIMEOUT cycles after clock release, both lines Z, cmd_sent never asserted.
- Device leaves DAT high on the 11th edge (NACK) → cmd_error pulses one cycle after that edge; no cmd_sent.
- Device stops clocking after the 4th edge → cmd_error after BIT_TIMEOUT cycles; a second cmd_send 0xF4 then completes normally.
- Reset asserted during the 6th data bit → PS2_CLK and PS2_DAT are Z within the same cycle, cmd_busy=0, no pulses; cmd_send pulsed during busy in an earlier run is ignored, with the frame content unchanged.
